// File: rtl/rglib_rotate_sched.sv
// Round-robin scheduler sharing one rglib_rotate between REQ_NUM requesters, with tagged,
// credit-limited response FIFO. Define RGLIB_ROTATE_SCHED_STAT_EN to add the stall_cnt output.
module rglib_rotate_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5,
  parameter int REQ_NUM     = 4,
  parameter int ROT_LATENCY = 1,
  parameter int RSP_DEPTH   = 4,
  parameter int ID_WIDTH    = $clog2(REQ_NUM)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               kill,
  input  logic [REQ_NUM-1:0]                 req_valid,
  output logic [REQ_NUM-1:0]                 req_ready,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]      req_data,
  input  logic [REQ_NUM*SHIFT_WIDTH-1:0]     req_rot,
  output logic                               rot_in_valid,
  output logic [DATA_WIDTH-1:0]              rot_in,
  output logic [SHIFT_WIDTH-1:0]             rot_val,
  input  logic                               rot_out_valid,
  input  logic [DATA_WIDTH-1:0]              rot_out,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [ID_WIDTH-1:0]                rsp_id,
`ifdef RGLIB_ROTATE_SCHED_STAT_EN
  output logic [15:0]                        stall_cnt,
`endif
  output logic [DATA_WIDTH-1:0]              rsp_data
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic [ID_WIDTH-1:0] rr_last;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                cand_found;
  logic                issue;
  logic [CNT_W-1:0]    credits;
  logic                sh_out_v;
  logic [ID_WIDTH-1:0] sh_out_id;
  logic                push;
  logic                pop;

  // Priority scan starts just after the last granted requester.
  always_comb begin
    int s;
    s          = 0;
    cand_found = 1'b0;
    grant_idx  = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      s = int'(rr_last) + k;
      if (s >= REQ_NUM) s = s - REQ_NUM;
      if (!cand_found && req_valid[ID_WIDTH'(s)]) begin
        cand_found = 1'b1;
        grant_idx  = ID_WIDTH'(s);
      end
    end
  end

  assign issue        = cand_found && (credits != '0) && !kill;
  assign rot_in_valid = issue;

  always_comb begin
    req_ready = '0;
    rot_in    = '0;
    rot_val   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        req_ready[i] = issue;
        rot_in       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        rot_val      = req_rot[i*SHIFT_WIDTH +: SHIFT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_last <= ID_WIDTH'(REQ_NUM - 1);
    else if (issue) rr_last <= grant_idx;
  end

  // Shadow of the rotator pipeline carrying the requester tag.
  generate
    if (ROT_LATENCY == 0) begin : g_shadow_comb
      assign sh_out_v  = issue;
      assign sh_out_id = grant_idx;
    end else begin : g_shadow_pipe
      logic [ROT_LATENCY-1:0] v_q;
      logic [ID_WIDTH-1:0]    id_q [ROT_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          for (int i = 0; i < ROT_LATENCY; i++) id_q[i] <= '0;
        end else begin
          for (int i = ROT_LATENCY - 1; i > 0; i--) begin
            v_q[i]  <= v_q[i-1] && !kill;
            id_q[i] <= id_q[i-1];
          end
          v_q[0]  <= issue;
          id_q[0] <= grant_idx;
        end
      end

      assign sh_out_v  = v_q[ROT_LATENCY-1];
      assign sh_out_id = id_q[ROT_LATENCY-1];
    end
  endgenerate

  logic [ID_WIDTH-1:0]   mem_id   [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = sh_out_v && !kill;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (count != '0);
  assign rsp_id    = mem_id[rd_ptr];
  assign rsp_data  = mem_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= DEPTH_C;
    end else if (kill) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= DEPTH_C;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count   <= count + CNT_W'(push) - CNT_W'(pop);
      credits <= credits + CNT_W'(pop) - CNT_W'(issue);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= sh_out_id;
      mem_data[wr_ptr] <= rot_out;
    end
  end

`ifdef RGLIB_ROTATE_SCHED_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (kill)
      stall_cnt <= '0;
    else if ((|req_valid) && !issue && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  // Results still inside the rotator after a kill legitimately lack a shadow entry.
  logic [7:0] kill_tmr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                kill_tmr <= '0;
    else if (kill)             kill_tmr <= 8'(ROT_LATENCY);
    else if (kill_tmr != '0)   kill_tmr <= kill_tmr - 8'd1;
  end

  a_shadow_match: assert property (@(posedge clk)
    disable iff (!rst_n || kill || (kill_tmr != '0)) sh_out_v == rot_out_valid);

endmodule
